// File: rtl/axi_pkg.sv
// +-----------------------------------------------------------------------------
// | axi_pkg : shared response codes and FSM state types for axi_mem_slave
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_DATA = 2'b10
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_mem_array.sv
// +-----------------------------------------------------------------------------
// | axi_mem_array : DEPTH x DATA_W storage, byte-strobed write, registered read
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module axi_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_mem_slave.sv
// +-----------------------------------------------------------------------------
// | axi_mem_slave : AXI-style memory slave, independent write/read channels.
// | Optional macro AXI_SLVERR_EN: out-of-range accesses answer SLVERR.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          r_resp,
  output logic                rdata_valid,
  input  logic                rdata_ready
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] LAT_LAST = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
`ifdef AXI_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  // ---------------- write channel ----------------
  wr_state_t           wr_state, wr_next;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_hs, w_hs, commit, wr_err;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  resp_t               b_resp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next     = wr_state;
    aw_ready    = 1'b0;
    wdata_ready = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    commit      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        aw_ready    = !aw_held;
        wdata_ready = !w_held;
        aw_hs       = aw_valid && !aw_held;
        w_hs        = wdata_valid && !w_held;
        commit      = (aw_held || aw_hs) && (w_held || w_hs);
        if (commit) wr_next = W_RESP;
      end
      W_RESP: begin
        if (b_ready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // The last half of the pair to arrive is taken straight from the bus.
  assign wr_addr = aw_held ? aw_addr_q : aw_addr;
  assign wr_data = w_held  ? wdata_q   : wdata;
  assign wr_strb = w_held  ? wstrb_q   : wstrb;
  assign wr_err  = SLVERR_EN && (32'(wr_addr) >= 32'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      b_resp_q <= OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      b_resp_q <= wr_err ? SLVERR : OKAY;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= aw_addr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  assign b_valid = (wr_state == W_RESP);
  assign b_resp  = b_resp_q;

  // ---------------- read channel ----------------
  rd_state_t           rd_state, rd_next;
  logic [3:0]          wait_cnt;
  logic [IDX_W-1:0]    ar_idx_q, rd_idx;
  logic                rd_err_q, ar_err, rd_sample;
  logic [DATA_W-1:0]   mem_q;
  resp_t               r_resp_q;

  assign ar_err = SLVERR_EN && (32'(ar_addr) >= 32'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next   = rd_state;
    ar_ready  = 1'b0;
    rd_sample = 1'b0;
    rd_idx    = ar_idx_q;
    case (rd_state)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (ar_valid) begin
          if (RD_LAT == 0) begin
            rd_sample = 1'b1;
            rd_idx    = ar_addr[IDX_W-1:0];
            rd_next   = R_DATA;
          end else begin
            rd_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          rd_sample = 1'b1;
          rd_next   = R_DATA;
        end
      end
      R_DATA: begin
        if (rdata_valid && rdata_ready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Memory output is registered on the sample edge; it reaches the bus one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 4'd0;
      ar_idx_q    <= '0;
      rd_err_q    <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      r_resp_q    <= OKAY;
    end else begin
      if (rd_state == R_IDLE && ar_valid) begin
        ar_idx_q <= ar_addr[IDX_W-1:0];
        rd_err_q <= ar_err;
      end
      wait_cnt <= (rd_state == R_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (rd_state == R_DATA && !rdata_valid) begin
        rdata_valid <= 1'b1;
        rdata       <= rd_err_q ? '0 : mem_q;
        r_resp_q    <= rd_err_q ? SLVERR : OKAY;
      end else if (rdata_valid && rdata_ready) begin
        rdata_valid <= 1'b0;
      end
    end
  end

  assign r_resp = r_resp_q;

  axi_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_mem (
    .clk   (clk),
    .we    (commit && !wr_err),
    .waddr (wr_addr[IDX_W-1:0]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (rd_sample),
    .raddr (rd_idx),
    .rdata (mem_q)
  );

endmodule

`default_nettype wire
